// File: rtl/imm_dec_ctrl.sv
// imm_dec_ctrl: RV32I immediate-decode stage with output register plus skid register and issue counter
module imm_dec_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [5:0]       out_extop,
  output logic [4:0]       out_iimm_shamt,
  output logic [11:0]      out_iimm,
  output logic [11:0]      out_simm,
  output logic [11:0]      out_bimm,
  output logic [19:0]      out_uimm,
  output logic [19:0]      out_jimm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  logic acc, con;
  logic [6:0] op;
  logic [2:0] f3;
  logic [5:0] in_extop, skid_extop;
  logic in_illegal, skid_illegal;
  logic [31:0] skid_instr, skid_pc;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  always_comb begin
    in_extop = (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) ? 6'b100000 :
               (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) ? 6'b010000 :
               (op == 7'b0100011) ? 6'b001000 :
               (op == 7'b1100011) ? 6'b000100 :
               (op == 7'b0110111 || op == 7'b0010111) ? 6'b000010 :
               (op == 7'b1101111) ? 6'b000001 : 6'b000000;
    in_illegal = (in_extop == 6'b0) && (op != 7'b0110011);
  end
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign acc = in_valid && in_ready && !flush;
  assign con = out_valid && out_ready && !flush;
  always_comb begin
    nxt = flush ? EMPTY :
          (state == EMPTY) ? (acc ? ONE : EMPTY) :
          (state == ONE) ? ((acc && !con) ? TWO : (!acc && con) ? EMPTY : ONE) :
          (con ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr    <= '0;
      out_pc       <= '0;
      out_extop    <= '0;
      out_illegal  <= 1'b0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_extop   <= '0;
      skid_illegal <= 1'b0;
      issue_cnt    <= '0;
    end else begin
      if (acc && (state == EMPTY || con)) begin
        out_instr   <= in_instr;
        out_pc      <= in_pc;
        out_extop   <= in_extop;
        out_illegal <= in_illegal;
      end else if (con && state == TWO) begin
        out_instr   <= skid_instr;
        out_pc      <= skid_pc;
        out_extop   <= skid_extop;
        out_illegal <= skid_illegal;
      end
      if (acc && state == ONE && !con) begin
        skid_instr   <= in_instr;
        skid_pc      <= in_pc;
        skid_extop   <= in_extop;
        skid_illegal <= in_illegal;
      end
      if (con) issue_cnt <= issue_cnt + 1'b1;
    end
  end
  assign out_iimm_shamt = out_instr[24:20];
  assign out_iimm       = out_instr[31:20];
  assign out_simm       = {out_instr[31:25], out_instr[11:7]};
  assign out_bimm       = {out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8]};
  assign out_uimm       = out_instr[31:12];
  assign out_jimm       = {out_instr[31], out_instr[19:12], out_instr[20], out_instr[30:21]};
endmodule

// File: tb/tb_imm_dec_ctrl.sv
// tb_imm_dec_ctrl: randomized and directed bench comparing imm_dec_ctrl against a queue-based model
module tb_imm_dec_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc;
  logic [5:0] out_extop;
  logic [4:0] out_iimm_shamt;
  logic [11:0] out_iimm, out_simm, out_bimm;
  logic [19:0] out_uimm, out_jimm;
  logic [15:0] issue_cnt;
  logic s_in_ready, s_out_valid, s_out_illegal;
  logic [31:0] s_out_instr, s_out_pc;
  logic [5:0] s_out_extop;
  logic [4:0] s_out_iimm_shamt;
  logic [11:0] s_out_iimm, s_out_simm, s_out_bimm;
  logic [19:0] s_out_uimm, s_out_jimm;
  logic [3:0] s_issue_cnt;
  int tests = 0, fails = 0;
  logic chk_en = 1'b0;
  logic [63:0] mq[$];
  int unsigned mcnt = 0;
  always #5 clk = ~clk;
  imm_dec_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_extop(out_extop),
    .out_iimm_shamt(out_iimm_shamt), .out_iimm(out_iimm), .out_simm(out_simm),
    .out_bimm(out_bimm), .out_uimm(out_uimm), .out_jimm(out_jimm),
    .out_illegal(out_illegal), .issue_cnt(issue_cnt)
  );
  imm_dec_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc), .out_extop(s_out_extop),
    .out_iimm_shamt(s_out_iimm_shamt), .out_iimm(s_out_iimm), .out_simm(s_out_simm),
    .out_bimm(s_out_bimm), .out_uimm(s_out_uimm), .out_jimm(s_out_jimm),
    .out_illegal(s_out_illegal), .issue_cnt(s_issue_cnt)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] exp_dec(input logic [31:0] i);
    logic [6:0] o;
    logic [2:0] f;
    o = i[6:0];
    f = i[14:12];
    if (o == 7'h13) return (f == 3'd1 || f == 3'd5) ? 7'b0100000 : 7'b0010000;
    if (o == 7'h03 || o == 7'h67) return 7'b0010000;
    if (o == 7'h23) return 7'b0001000;
    if (o == 7'h63) return 7'b0000100;
    if (o == 7'h37 || o == 7'h17) return 7'b0000010;
    if (o == 7'h6F) return 7'b0000001;
    if (o == 7'h33) return 7'b0000000;
    return 7'b1000000;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) mq.delete();
    else begin
      int n;
      n = mq.size();
      if (n > 0 && out_ready) begin
        void'(mq.pop_front());
        mcnt++;
      end
      if (in_valid && n < 2) mq.push_back({in_pc, in_instr});
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ei;
      logic [6:0] d;
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("issue_cnt", issue_cnt, mcnt % 65536);
      chk("issue_cnt_w4", s_issue_cnt, mcnt % 16);
      chk("w4_out_valid", s_out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        ei = mq[0][31:0];
        d = exp_dec(ei);
        chk("out_instr", out_instr, ei);
        chk("out_pc", out_pc, mq[0][63:32]);
        chk("out_extop", out_extop, d[5:0]);
        chk("out_illegal", out_illegal, d[6]);
        chk("out_iimm_shamt", out_iimm_shamt, ei[24:20]);
        chk("out_iimm", out_iimm, ei[31:20]);
        chk("out_simm", out_simm, {ei[31:25], ei[11:7]});
        chk("out_bimm", out_bimm, {ei[31], ei[7], ei[30:25], ei[11:8]});
        chk("out_uimm", out_uimm, ei[31:12]);
        chk("out_jimm", out_jimm, {ei[31], ei[19:12], ei[20], ei[30:21]});
      end
    end
  end
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic r);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [6:0] ops [10];
    logic [15:0] c0;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; rst = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    chk_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_extop", out_extop, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    cyc(1, 32'h00500093, 32'h100, 1, 0, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_extop", out_extop, 6'b010000);
    chk("addi_iimm", out_iimm, 12'h005);
    cyc(1, 32'h00209093, 32'h104, 1, 0, 0);
    chk("addi_cnt", issue_cnt, 1);
    chk("slli_extop", out_extop, 6'b100000);
    chk("slli_shamt", out_iimm_shamt, 5'd2);
    cyc(1, 32'h0000006F, 32'h108, 1, 0, 0);
    chk("jal_extop", out_extop, 6'b000001);
    chk("jal_jimm", out_jimm, 20'h0);
    cyc(1, 32'hFFFFFFFF, 32'h10C, 1, 0, 0);
    chk("ill_illegal", out_illegal, 1);
    chk("ill_extop", out_extop, 0);
    cyc(1, 32'h002081B3, 32'h110, 1, 0, 0);
    chk("add_illegal", out_illegal, 0);
    chk("add_extop", out_extop, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_cnt", issue_cnt, 5);
    cyc(1, 32'hA0000013, 32'h200, 0, 0, 0);
    chk("skid_a", out_instr, 32'hA0000013);
    cyc(1, 32'hB0000013, 32'h204, 0, 0, 0);
    chk("skid_full", in_ready, 0);
    chk("skid_a_held", out_instr, 32'hA0000013);
    cyc(1, 32'hC0000013, 32'h208, 0, 0, 0);
    chk("skid_c_held", out_instr, 32'hA0000013);
    cyc(1, 32'hC0000013, 32'h208, 1, 0, 0);
    chk("order_b", out_instr, 32'hB0000013);
    cyc(1, 32'hC0000013, 32'h208, 1, 0, 0);
    chk("order_c", out_instr, 32'hC0000013);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h00000037, 32'h300, 0, 0, 0);
    cyc(1, 32'h00000063, 32'h304, 0, 0, 0);
    c0 = issue_cnt;
    cyc(1, 32'h00000023, 32'h308, 1, 1, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", issue_cnt, c0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] r;
      r = $urandom();
      cyc($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 9)]}, $urandom(),
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 18; k++) cyc(1, 32'h00100013 + k, k * 4, 1, 0, 0);
    chk("wrap_w4", s_issue_cnt, 4'd1);
    chk("wrap_w16", issue_cnt, 16'd17);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_dec_ctrl.md
IMM_DEC_CTRL -- requirements
Module: imm_dec_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of issued-instruction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  fetch side presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_instr  input  32  raw RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 flush  input  1  discard all held and incoming instructions (branch redirect).
REQ-009 out_valid  output  1  decoded entry presented to execute.
REQ-010 out_ready  input  1  execute consumes the entry this cycle.
REQ-011 out_instr, out_pc  output  32 each  instruction and PC of the presented entry.
REQ-012 out_extop  output  6  EXTOp for the immediate extender.
REQ-013 out_iimm_shamt 5, out_iimm 12, out_simm 12, out_bimm 12, out_uimm 20, out_jimm 20  output  immediate fields for the extender.
REQ-014 out_illegal  output  1  presented entry has an unrecognised opcode.
REQ-015 issue_cnt  output  CNT_W  count of entries handed to execute.

Function
REQ-016 Decode (opcode = instr[6:0]) SHALL select EXTOp one-hot: ITYPE_SHAMT 6'b100000, ITYPE 6'b010000, STYPE 6'b001000, BTYPE 6'b000100, UTYPE 6'b000010, JTYPE 6'b000001, matching ctrl_encode_def.v.
REQ-017 0010011 with funct3 001 or 101 -> ITYPE_SHAMT; 0010011 other funct3, 0000011, 1100111 -> ITYPE; 0100011 -> STYPE; 1100011 -> BTYPE; 0110111, 0010111 -> UTYPE; 1101111 -> JTYPE.
REQ-018 0110011 -> EXTOp 0, illegal 0; any other opcode -> EXTOp 0, illegal 1.
REQ-019 Fields SHALL be: iimm_shamt=instr[24:20]; iimm=instr[31:20]; simm={instr[31:25],instr[11:7]}; bimm={instr[31],instr[7],instr[30:25],instr[11:8]}; uimm=instr[31:12]; jimm={instr[31],instr[19:12],instr[20],instr[30:21]}.
REQ-020 Decode SHALL occur on accept; all out_* SHALL come from registers, no combinational path in_instr -> out_*.
REQ-021 Storage: output register (OUT) plus one skid register (SKID); FSM states EMPTY (none valid), ONE (OUT valid), TWO (OUT and SKID valid).
REQ-022 in_ready SHALL equal (state != TWO), registered, no dependence on out_ready.
REQ-023 Accept = in_valid & in_ready & !flush; consume = out_valid & out_ready & !flush.
REQ-024 EMPTY: accept -> OUT loaded, ONE.
REQ-025 ONE: accept & consume -> OUT reloaded, ONE; accept only -> SKID loaded, TWO; consume only -> EMPTY.
REQ-026 TWO: consume -> SKID moves to OUT, ONE; no accept possible.
REQ-027 Latency: accepted instruction SHALL appear on out_* the next cycle when state was EMPTY or consumed-ONE; ordering SHALL be preserved.
REQ-028 out_valid SHALL equal (state != EMPTY).
REQ-029 flush SHALL, next cycle, force EMPTY, drop OUT and SKID, ignore in_valid that cycle, and not count a consume even if out_ready=1.
REQ-030 out_* data SHALL hold stable while out_valid & !out_ready.
REQ-031 issue_cnt SHALL increment by 1 per consume, wrap modulo 2^CNT_W, unaffected by flush.

Reset
REQ-032 rst SHALL, at the next clk edge, set state EMPTY, out_valid 0, in_ready 1, issue_cnt 0, out_extop 0, out_illegal 0, all out_* data 0.
REQ-033 rst SHALL override flush, accept and consume in the same cycle; mid-operation reset discards held entries without counting.

Verification
REQ-034 Reset then in_valid=1 instr 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_extop=6'b010000, out_iimm=12'h005, issue_cnt=1 the cycle after.
REQ-035 instr 0x00209093 (slli x1,x1,2) -> out_extop=6'b100000, out_iimm_shamt=5'd2; instr 0x0000006F (jal x0,0) -> 6'b000001, out_jimm=0.
REQ-036 out_ready=0, three back-to-back in_valid (A,B,C) -> A on OUT, B in SKID, in_ready=0, C held; out_ready=1 -> A, B, C emerge in order on consecutive cycles.
REQ-037 State TWO, flush=1 with out_ready=1 -> next cycle out_valid=0, in_ready=1, issue_cnt unchanged.
REQ-038 instr 0xFFFFFFFF -> out_illegal=1, out_extop=0; 0x002081B3 (add) -> out_illegal=0, out_extop=0.
REQ-039 CNT_W=4, 17 consumes -> issue_cnt=1 (wrap).
